// File: rtl/decim_fifo_pkg.sv
// Shared defaults and derived widths for the decimating averager and its output FIFO.
package decim_pkg;

  localparam int unsigned DEF_DW    = 12;
  localparam int unsigned DEF_LOG2R = 2;
  localparam int unsigned DEF_DEPTH = 4;

  // Accumulator holds R samples of DW bits without wrap.
  localparam int unsigned ACC_W = DEF_DW + DEF_LOG2R;
  // FIFO occupancy needs one bit beyond the pointer width to represent "full".
  localparam int unsigned CNT_W = $clog2(DEF_DEPTH) + 1;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned log2r);
    return dw + log2r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decim_fifo_if.sv
// Sample stream in, decimated FWFT stream out, plus status.
interface decim_fifo_if
  import decim_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned CNT_W = cnt_width(DEF_DEPTH)
) ();

  logic                    flush;
  logic                    din_valid;
  logic signed [DW-1:0]    din;
  logic signed [DW-1:0]    dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic        [CNT_W-1:0] fill_level;
  logic                    overflow;

  modport master (
    output flush, din_valid, din, dout_ready,
    input  dout, dout_valid, fill_level, overflow
  );

  modport slave (
    input  flush, din_valid, din, dout_ready,
    output dout, dout_valid, fill_level, overflow
  );

endinterface

// File: rtl/decim_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy count.
// While empty the output holds the last popped word (zero after reset).
module sync_fifo
  import decim_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_pop,
  output logic [DW-1:0]    o_rdata,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DW-1:0]    r_hold;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Handshake qualification: a pop frees a slot, so a full FIFO can still accept a push.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_W'(DEPTH));
    w_pop   = i_pop && !w_empty;
    w_push  = i_push && (!w_full || w_pop);
    o_valid = !w_empty;
    o_full  = w_full;
    o_count = r_count;
    o_rdata = w_empty ? r_hold : r_mem[r_rd_ptr];
  end

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and held output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/decim_fifo.sv
// Decimate-by-R block averager (round-half-up) feeding a FWFT output FIFO.
module decim_fifo
  import decim_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LOG2R = DEF_LOG2R,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  decim_fifo_if.slave  bus
);

  localparam int unsigned AW_ACC = acc_width(DW, LOG2R);
  localparam int unsigned CW     = cnt_width(DEPTH);
  localparam logic signed [AW_ACC-1:0] RND = AW_ACC'(1) << (LOG2R - 1);

  logic signed [AW_ACC-1:0] r_acc;
  logic        [LOG2R-1:0]  r_phase;
  logic                     r_ovf;

  logic signed [AW_ACC-1:0] w_din_ext;
  logic signed [AW_ACC-1:0] w_sum;
  logic signed [AW_ACC-1:0] w_rnd;
  logic        [DW-1:0]     w_avg;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_valid;
  logic                     w_full;
  logic        [CW-1:0]     w_count;

  // Group sum including the current sample, rounded average and push/pop decode.
  // The sum of R in-range samples plus R/2 cannot exceed ACC_W signed range.
  always_comb begin
    w_din_ext = {{LOG2R{bus.din[DW-1]}}, bus.din};
    w_sum     = r_acc + w_din_ext;
    w_rnd     = w_sum + RND;
    w_avg     = DW'(w_rnd >>> LOG2R);
    w_last    = bus.din_valid && (r_phase == '1);
    w_push    = w_last && !bus.flush;
    w_pop     = bus.dout_ready && w_valid;
  end

  // Accumulator, phase counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_phase <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.flush) begin
      r_acc   <= '0;
      r_phase <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.din_valid) begin
        if (w_last) begin
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + 1'b1;
        end
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_wdata (w_avg),
    .i_pop   (bus.dout_ready),
    .o_rdata (bus.dout),
    .o_valid (w_valid),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign bus.dout_valid = w_valid;
  assign bus.fill_level = w_count;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_decim_fifo.sv
// Scoreboard bench for decim_fifo: a group-average reference model fills an
// expected-sample queue; a negedge monitor checks status and the FIFO head.
module tb_decim_fifo;
  import decim_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int LOG2R = DEF_LOG2R;
  localparam int DEPTH = DEF_DEPTH;
  localparam int R     = 1 << LOG2R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decim_fifo_if #(.DW(DEF_DW), .CNT_W(CNT_W)) ifc ();

  decim_fifo #(.DW(DEF_DW), .LOG2R(DEF_LOG2R), .DEPTH(DEF_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_q[$];
  int grp[$];
  int m_cnt  = 0;
  int m_ovf  = 0;
  int m_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor((sum + R/2) / R)
  function automatic int avg_of(input int s);
    int t;
    t = s + R / 2;
    if (t >= 0) return t / R;
    return -((-t + R - 1) / R);
  endfunction

  // Reference behaviour of one clock edge given the inputs held during that cycle.
  task automatic model(input bit r, input bit f, input bit v, input int d, input bit rd);
    bit pop;
    bit push;
    int a;
    if (!r || f) begin
      grp.delete();
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 0;
      if (!r) m_last = 0;
      return;
    end
    pop  = rd && (m_cnt > 0);
    push = 1'b0;
    a    = 0;
    if (v) begin
      grp.push_back(d);
      if (grp.size() == R) begin
        a = avg_of(grp.sum());
        push = 1'b1;
        grp.delete();
      end
    end
    if (push) begin
      if (m_cnt == DEPTH && !pop) begin
        m_ovf = 1;
      end else begin
        exp_q.push_back(a);
        m_cnt++;
      end
    end
    if (pop) m_cnt--;
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input int d, input bit rd);
    rst_n          = r;
    ifc.flush      = f;
    ifc.din_valid  = v;
    ifc.din        = DW'(d);
    ifc.dout_ready = rd;
    @(posedge clk);
    #1;
    model(r, f, v, d, rd);
  endtask

  // Monitor: status against model, head of FIFO against scoreboard queue.
  always @(negedge clk) begin
    chk("dout_valid", int'(ifc.dout_valid), int'(m_cnt > 0));
    chk("fill_level", int'(ifc.fill_level), m_cnt);
    chk("overflow",   int'(ifc.overflow),   m_ovf);
    if (ifc.dout_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dout: valid with value %0d, expected no sample at %0t", int'(ifc.dout), $time);
      end else begin
        chk("dout", int'(ifc.dout), exp_q[0]);
        if (ifc.dout_ready && rst_n && !ifc.flush) begin
          m_last = exp_q.pop_front();
        end
      end
    end else begin
      chk("dout_hold", int'(ifc.dout), m_last);
    end
  end

  int rnd_vals[16] = '{1, 1, 1, 0, -1, -1, -1, -2,
                       2047, 2047, 2047, 2047, -2048, -2048, -2048, -2048};

  initial begin
    ifc.flush      = 1'b0;
    ifc.din_valid  = 1'b0;
    ifc.din        = '0;
    ifc.dout_ready = 1'b0;

    // Reset held with live input, then four fresh samples
    repeat (3) cyc(0, 0, 1, 500, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 500, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);

    // Constant input
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 100, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);

    // Rounding and extremes
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, rnd_vals[i], 1);
    repeat (2) cyc(1, 0, 0, 0, 1);

    // Backpressure into overflow, then drain
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, i, 0);
    repeat (8) cyc(1, 0, 0, 0, 1);

    // Full FIFO with pop on the group-completing edge
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 10 * i, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 300, 0);
    cyc(1, 0, 1, 300, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);

    // Mid-group flush, then mid-group reset
    cyc(1, 0, 1, 50, 1);
    cyc(1, 0, 1, 50, 1);
    cyc(1, 1, 1, 50, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 50, 1);
    cyc(1, 0, 1, 50, 1);
    cyc(0, 0, 1, 50, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, f, v, rd;
      int d;
      r  = ($urandom_range(0, 149) != 0);
      f  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       d = 2047;
        1:       d = -2048;
        default: d = int'($urandom_range(0, 4095)) - 2048;
      endcase
      cyc(r, f, v, d, rd);
    end

    // Bounded drain
    for (int i = 0; i < 2 * DEPTH + 4; i++) cyc(1, 0, 0, 0, 1);
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decim_fifo.md
DECIM_FIFO -- requirements
Module: decim_fifo

Interface
REQ-001 Parameter DW, default 12: signed sample width, equal to the IIR output width.
REQ-002 Parameter LOG2R, default 2: log2 of the decimation ratio R (R = 4); legal range 1..4.
REQ-003 Parameter DEPTH, default 4: output FIFO depth in entries; power of 2, at least 2.
REQ-004 clk  in  1  single rising-edge clock, same domain as the IIR stage.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 flush  in  1  synchronous clear of datapath state.
REQ-007 din_valid  in  1  din carries a sample this cycle.
REQ-008 din  in  DW  signed sample from the IIR dout.
REQ-009 dout  out  DW  signed decimated sample at the FIFO head.
REQ-010 dout_valid  out  1  FIFO non-empty.
REQ-011 dout_ready  in  1  consumer accepts dout when it is high together with dout_valid.
REQ-012 fill_level  out  clog2(DEPTH)+1  number of FIFO entries.
REQ-013 overflow  out  1  sticky flag: a decimated sample was dropped.

Function
REQ-014 Each cycle with din_valid=1 shall add din, sign-extended to DW+LOG2R bits, to the accumulator and advance a phase counter 0..R-1.
REQ-015 When the R-th sample arrives (phase=R-1), the block shall form avg = (acc + din + 2^(LOG2R-1)) >>> LOG2R (arithmetic shift, round-half-up).
REQ-016 On that same edge, the block shall truncate avg to DW bits, push it into the FIFO, clear the accumulator and set phase to 0.
REQ-017 avg is bounded to [-2^(DW-1), 2^(DW-1)-1] by construction; no saturation logic is required.
REQ-018 Cycles with din_valid=0 shall not change the accumulator or phase.
REQ-019 Latency: a pushed sample shall appear on dout, with dout_valid=1, in the cycle after the edge that completes the R-th input, provided the FIFO was empty.
REQ-020 The FIFO is first-word-fall-through: dout shall always show the oldest entry, and a pop occurs on an edge where dout_valid and dout_ready are both high.
REQ-021 A push while full with no pop shall drop the new sample, set overflow=1, and still clear the accumulator and phase.
REQ-022 A push and a pop on the same edge while full shall both succeed, with no overflow and fill_level unchanged.
REQ-023 A push and a pop on the same edge with 0 < fill < DEPTH shall leave fill_level unchanged; a push into an empty FIFO shall not be poppable until the next cycle.
REQ-024 dout_ready while empty shall have no effect; dout shall hold its last value and is don't-care while dout_valid=0.
REQ-025 flush=1 shall, on the edge, clear the accumulator, phase, FIFO pointers and overflow; a din sample present in that cycle is discarded.
REQ-026 flush shall take priority over push, pop and accumulation.

Reset
REQ-027 rst_n=0 on an edge shall set dout=0, dout_valid=0, fill_level=0, overflow=0, accumulator=0, phase=0 and both FIFO pointers to 0.
REQ-028 Reset shall take priority over flush and all other activity; a partially accumulated group is discarded.
REQ-029 FIFO storage contents need no reset.

Structure
REQ-030 A shared package decim_pkg shall hold DW, LOG2R and DEPTH defaults and the derived widths ACC_W = DW+LOG2R and CNT_W = clog2(DEPTH)+1.
REQ-031 The FIFO shall be one sub-module, sync_fifo (FWFT, push/pop/flush, count output); the accumulator and phase logic live in decim_fifo.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles with din_valid=1 and din=500 -> all outputs 0 throughout; after release, the first output appears only after 4 new samples.
REQ-033 Constant input: din=100 valid for 8 cycles, dout_ready=1 -> dout=100 in exactly two single-cycle valid pulses, 1 cycle after samples 4 and 8.
REQ-034 Rounding and extremes: groups {1,1,1,0}, {-1,-1,-1,-2}, {2047 x4}, {-2048 x4} -> outputs 1, -1, 2047, -2048.
REQ-035 Backpressure: dout_ready=0, 20 samples 0..19 (group averages 2,6,10,14,18) -> fill_level=4, overflow=1; then dout_ready=1 -> drains 2,6,10,14 in order and overflow stays 1.
REQ-036 Full with simultaneous pop: FIFO full, dout_ready=1 on the edge completing a group -> no overflow, fill stays 4, new sample is the last one drained.
REQ-037 Mid-operation clear: flush after 2 samples of a group, then 4 samples of 8 -> single output 8, overflow=0; repeat with a rst_n pulse -> same result.
